// File: rtl/acc_reg_file_v2_pkg.sv
// Shared definitions for the accumulator register file: context-sequencer states,
// copy direction and default geometry.
package acc_reg_file_v2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAVE,
        RESTORE
    } rf_state_e;

    typedef enum logic {
        DIR_SAVE,
        DIR_RESTORE
    } rf_dir_e;

    localparam int unsigned DEFAULT_DW  = 8;
    localparam int unsigned DEFAULT_RAW = 4;

endpackage

// File: rtl/acc_reg_file_v2_rf_ctx_seq.sv
// Save/restore context sequencer: waits for outstanding loads to drain, then walks
// the copy index across every entry, one per cycle.
module rf_ctx_seq
    import acc_reg_file_v2_pkg::*;
#(
    parameter int unsigned RAW = DEFAULT_RAW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           save_req_i,
    input  logic           restore_req_i,
    input  logic           any_busy_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           copy_en_o,
    output rf_dir_e        copy_dir_o,
    output logic [RAW-1:0] copy_idx_o
);

    rf_state_e      state_q, state_d;
    rf_dir_e        dir_q, dir_d;
    logic [RAW-1:0] idx_q, idx_d;
    logic           done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_SAVE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (save_req_i || restore_req_i) begin
                    dir_d = save_req_i ? DIR_SAVE : DIR_RESTORE;
                    idx_d = '0;
                    if (any_busy_i)
                        state_d = WAIT;
                    else
                        state_d = save_req_i ? SAVE : RESTORE;
                end
            end
            WAIT: begin
                if (!any_busy_i)
                    state_d = (dir_q == DIR_SAVE) ? SAVE : RESTORE;
            end
            SAVE, RESTORE: begin
                if (idx_q == '1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign copy_en_o  = (state_q == SAVE) || (state_q == RESTORE);
    assign copy_dir_o = (state_q == SAVE) ? DIR_SAVE : DIR_RESTORE;
    assign copy_idx_o = idx_q;

endmodule

// File: rtl/acc_reg_file_v2.sv
// Accumulator register file with late load-return port, busy scoreboard and shadow bank.
// Optional macro RF_BYPASS_EN enables same-cycle write-to-read forwarding.
module acc_reg_file_v2
    import acc_reg_file_v2_pkg::*;
#(
    parameter int unsigned DW    = DEFAULT_DW,
    parameter int unsigned RAW   = DEFAULT_RAW,
    parameter int unsigned IMM_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RAW-1:0]        rt_addr_i,
    input  logic                  reg_read_i,
    input  logic [RAW-1:0]        write_addr_i,
    input  logic                  acc_wen_i,
    input  logic                  reg_wen_i,
    input  logic [DW-1:0]         write_data_i,
    input  logic                  ld_issue_i,
    input  logic [RAW-1:0]        ld_addr_i,
    input  logic                  ld_ret_i,
    input  logic [RAW-1:0]        ld_ret_addr_i,
    input  logic [DW-1:0]         ld_ret_data_i,
    input  logic                  save_req_i,
    input  logic                  restore_req_i,
    output logic [DW-1:0]         rs_val_o,
    output logic [DW-1:0]         rt_val_o,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DW*(2**RAW)-1:0] rf_o
);

    localparam int unsigned DEPTH = 2**RAW;

    logic [DEPTH-1:0][DW-1:0] rf_q, rf_d;
    logic [DEPTH-1:0][DW-1:0] sh_q, sh_d;
    logic [DEPTH-1:0]         busy_q, busy_d;

    logic           seq_busy;
    logic           copy_en;
    rf_dir_e        copy_dir;
    logic [RAW-1:0] copy_idx;
    logic           alu_ok, ret_ok, issue_ok;

    rf_ctx_seq #(.RAW(RAW)) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .save_req_i   (save_req_i),
        .restore_req_i(restore_req_i),
        .any_busy_i   (|busy_q),
        .busy_o       (seq_busy),
        .done_o       (done_o),
        .copy_en_o    (copy_en),
        .copy_dir_o   (copy_dir),
        .copy_idx_o   (copy_idx)
    );

    // Load returns are accepted in IDLE and WAIT, but not while the copy owns the bank.
    assign alu_ok   = !seq_busy;
    assign ret_ok   = ld_ret_i && !copy_en;
    assign issue_ok = ld_issue_i && !seq_busy;

    // Later assignments override earlier ones: load return beats ALU, acc beats reg.
    always_comb begin
        rf_d   = rf_q;
        sh_d   = sh_q;
        busy_d = busy_q;
        if (copy_en) begin
            if (copy_dir == DIR_SAVE)
                sh_d[copy_idx] = rf_q[copy_idx];
            else
                rf_d[copy_idx] = sh_q[copy_idx];
        end
        if (alu_ok) begin
            if (acc_wen_i)
                rf_d[0] = write_data_i;
            else if (reg_wen_i)
                rf_d[write_addr_i] = write_data_i;
        end
        if (ret_ok) begin
            rf_d[ld_ret_addr_i]   = ld_ret_data_i;
            busy_d[ld_ret_addr_i] = 1'b0;
        end
        if (issue_ok)
            busy_d[ld_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q   <= '0;
            sh_q   <= '0;
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            sh_q   <= sh_d;
            busy_q <= busy_d;
        end
    end

    logic [DEPTH-1:0][DW-1:0] rd_bank;
    logic [DEPTH-1:0]         rd_busy;
    logic [DW-1:0]            imm_val;

`ifdef RF_BYPASS_EN
    logic [DEPTH-1:0] ret_mask;
    always_comb begin
        ret_mask = '0;
        if (ret_ok)
            ret_mask[ld_ret_addr_i] = 1'b1;
    end
    assign rd_bank = rf_d;
    assign rd_busy = busy_q & ~ret_mask;
`else
    assign rd_bank = rf_q;
    assign rd_busy = busy_q;
`endif

    always_comb begin
        imm_val              = '0;
        imm_val[IMM_W-1:0]   = rt_addr_i[IMM_W-1:0];
    end

    assign rs_val_o = rd_bank[0];
    assign rt_val_o = reg_read_i ? rd_bank[rt_addr_i] : imm_val;
    assign stall_o  = rd_busy[0] | (reg_read_i & rd_busy[rt_addr_i]);
    assign busy_o   = seq_busy;
    assign rf_o     = rf_q;

endmodule

// File: tb/tb_acc_reg_file_v2.sv
// Self-checking bench for acc_reg_file_v2: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_acc_reg_file_v2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   rt_addr, write_addr, ld_addr, ld_ret_addr;
    logic         reg_read, acc_wen, reg_wen, ld_issue, ld_ret, save_req, restore_req;
    logic [7:0]   write_data, ld_ret_data;
    logic [7:0]   rs_val, rt_val;
    logic         stall, busy, done;
    logic [127:0] rf;

    int checks = 0;
    int errors = 0;

    acc_reg_file_v2 #(.DW(8), .RAW(4), .IMM_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rt_addr_i    (rt_addr),
        .reg_read_i   (reg_read),
        .write_addr_i (write_addr),
        .acc_wen_i    (acc_wen),
        .reg_wen_i    (reg_wen),
        .write_data_i (write_data),
        .ld_issue_i   (ld_issue),
        .ld_addr_i    (ld_addr),
        .ld_ret_i     (ld_ret),
        .ld_ret_addr_i(ld_ret_addr),
        .ld_ret_data_i(ld_ret_data),
        .save_req_i   (save_req),
        .restore_req_i(restore_req),
        .rs_val_o     (rs_val),
        .rt_val_o     (rt_val),
        .stall_o      (stall),
        .busy_o       (busy),
        .done_o       (done),
        .rf_o         (rf)
    );

    always #5 clk = ~clk;

    // Reference model: live bank, shadow bank, busy flags, and context-switch progress
    // (0 = none, 1 = waiting for loads, 2 = copying; m_left = entries still to copy).
    logic [7:0] m_live[16];
    logic [7:0] m_sh[16];
    bit         m_busy[16];
    int         m_phase;
    bit         m_save;
    int         m_left;
    bit         m_done;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_live[i] = 8'h00; m_sh[i] = 8'h00; m_busy[i] = 1'b0;
        end
        m_phase = 0; m_save = 1'b0; m_left = 0; m_done = 1'b0;
    endtask

    function automatic bit any_busy();
        bit b = 1'b0;
        for (int i = 0; i < 16; i++) b |= m_busy[i];
        return b;
    endfunction

    function automatic logic [127:0] exp_rf();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = m_live[i];
        return f;
    endfunction

    function automatic logic [7:0] exp_rt();
        return reg_read ? m_live[rt_addr] : {4'h0, rt_addr};
    endfunction

    function automatic logic exp_stall();
        return m_busy[0] | (reg_read & m_busy[rt_addr]);
    endfunction

    task automatic clear_inputs();
        rt_addr = 4'h0; reg_read = 1'b0; write_addr = 4'h0; acc_wen = 1'b0; reg_wen = 1'b0;
        write_data = 8'h00; ld_issue = 1'b0; ld_addr = 4'h0; ld_ret = 1'b0; ld_ret_addr = 4'h0;
        ld_ret_data = 8'h00; save_req = 1'b0; restore_req = 1'b0;
    endtask

    // Advance one clock, applying the register-file rules to the model.
    task automatic tick();
        logic [7:0] n_live[16];
        logic [7:0] n_sh[16];
        bit         n_busy[16];
        int         n_phase = m_phase;
        bit         n_save  = m_save;
        int         n_left  = m_left;
        bit         copying = (m_phase == 2);
        bit         idle    = (m_phase == 0);
        int         ci      = 16 - m_left;
        n_live = m_live; n_sh = m_sh; n_busy = m_busy;
        if (copying) begin
            if (m_save) n_sh[ci] = m_live[ci];
            else        n_live[ci] = m_sh[ci];
        end
        if (idle && acc_wen)      n_live[0] = write_data;
        else if (idle && reg_wen) n_live[write_addr] = write_data;
        if (ld_ret && !copying) begin
            n_live[ld_ret_addr] = ld_ret_data;
            n_busy[ld_ret_addr] = 1'b0;
        end
        if (ld_issue && idle) n_busy[ld_addr] = 1'b1;
        if (idle && (save_req || restore_req)) begin
            n_save  = save_req;
            n_left  = 16;
            n_phase = any_busy() ? 1 : 2;
        end else if (m_phase == 1 && !any_busy()) begin
            n_phase = 2;
        end else if (copying) begin
            n_left = m_left - 1;
            if (n_left == 0) n_phase = 0;
        end
        @(posedge clk);
        m_live = n_live; m_sh = n_sh; m_busy = n_busy;
        m_done  = copying && (m_left == 1);
        m_phase = n_phase; m_save = n_save; m_left = n_left;
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        reg_wen = 1'b1; write_addr = a; write_data = d;
        tick();
        reg_wen = 1'b0;
    endtask

    // Issue a request and run until done_o; reports busy_o cycles and whether done was seen.
    task automatic run_seq(input bit do_save, output int nbusy, output bit seen_done);
        save_req = do_save; restore_req = !do_save;
        tick();
        save_req = 1'b0; restore_req = 1'b0;
        nbusy = 0; seen_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (busy) nbusy++;
            if (done) begin seen_done = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        reg_read = 1'b1;
        model_clear();
        #12;
        checks++; if (rf !== 128'h0)  begin errors++; $display("FAIL reset_rf got %h want 0", rf); end
        checks++; if (rs_val !== 8'h0) begin errors++; $display("FAIL reset_rs got %h want 00", rs_val); end
        checks++; if (rt_val !== 8'h0) begin errors++; $display("FAIL reset_rt got %h want 00", rt_val); end
        checks++; if ({stall, busy, done} !== 3'b000)
            begin errors++; $display("FAIL reset_flags got %b want 000", {stall, busy, done}); end
        #8 rst_n = 1'b1;
        reg_read = 1'b0;
    endtask

    task automatic test_write_priority();
        acc_wen = 1'b1; reg_wen = 1'b1; write_addr = 4'h5; write_data = 8'h3C;
        tick();
        clear_inputs();
        checks++; if (rf[7:0] !== 8'h3C) begin errors++; $display("FAIL prio_acc got %h want 3c", rf[7:0]); end
        checks++; if (rf[47:40] !== 8'h00) begin errors++; $display("FAIL prio_r5 got %h want 00", rf[47:40]); end
        checks++; if (rs_val !== 8'h3C) begin errors++; $display("FAIL prio_rs got %h want 3c", rs_val); end
        reg_read = 1'b0; rt_addr = 4'hA;
        #1;
        checks++; if (rt_val !== 8'h0A) begin errors++; $display("FAIL imm_rt got %h want 0a", rt_val); end
    endtask

    task automatic test_scoreboard();
        ld_issue = 1'b1; ld_addr = 4'h3;
        tick();
        ld_issue = 1'b0;
        reg_read = 1'b1; rt_addr = 4'h3;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall got %b want 1", stall); end
        reg_read = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_imm_nostall got %b want 0", stall); end
        reg_read = 1'b1;
        ld_ret = 1'b1; ld_ret_addr = 4'h3; ld_ret_data = 8'h77;
        tick();
        ld_ret = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_clear got %b want 0", stall); end
        checks++; if (rt_val !== 8'h77) begin errors++; $display("FAIL sb_data got %h want 77", rt_val); end
        // Issue and return to the same entry together: the new load stays outstanding.
        ld_issue = 1'b1; ld_addr = 4'h4; ld_ret = 1'b1; ld_ret_addr = 4'h4; ld_ret_data = 8'h42;
        tick();
        clear_inputs();
        reg_read = 1'b1; rt_addr = 4'h4;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_reissue got %b want 1", stall); end
        ld_ret = 1'b1; ld_ret_addr = 4'h4; ld_ret_data = 8'h43;
        tick();
        clear_inputs();
    endtask

    task automatic test_collision();
        reg_wen = 1'b1; write_addr = 4'h7; write_data = 8'h11;
        ld_ret = 1'b1; ld_ret_addr = 4'h7; ld_ret_data = 8'h22;
        tick();
        clear_inputs();
        checks++; if (rf[63:56] !== 8'h22) begin errors++; $display("FAIL collide got %h want 22", rf[63:56]); end
        acc_wen = 1'b1; write_data = 8'h5E; ld_ret = 1'b1; ld_ret_addr = 4'h9; ld_ret_data = 8'hA9;
        tick();
        clear_inputs();
        checks++; if ({rf[7:0], rf[79:72]} !== 16'h5EA9)
            begin errors++; $display("FAIL dual_write got %h want 5ea9", {rf[7:0], rf[79:72]}); end
    endtask

    task automatic test_save_restore();
        int  nb;
        bit  dn;
        bit  ok;
        for (int i = 0; i < 16; i++) write_reg(4'(i), 8'(i + 1));
        run_seq(1'b1, nb, dn);
        checks++; if (!dn) begin errors++; $display("FAIL save_done got 0 want 1"); end
        checks++; if (nb != 16) begin errors++; $display("FAIL save_busy_cycles got %0d want 16", nb); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
        for (int i = 0; i < 16; i++) write_reg(4'(i), 8'hFF);
        run_seq(1'b0, nb, dn);
        checks++; if (!dn || nb != 16)
            begin errors++; $display("FAIL restore_seq got done=%0b busy=%0d want done=1 busy=16", dn, nb); end
        ok = 1'b1;
        for (int i = 0; i < 16; i++) if (rf[i*8 +: 8] !== 8'(i + 1)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL restore_data got %h", rf); end
        checks++; if (rf !== exp_rf()) begin errors++; $display("FAIL restore_model got %h want %h", rf, exp_rf()); end
    endtask

    task automatic test_wait_path();
        int nb;
        bit dn;
        ld_issue = 1'b1; ld_addr = 4'h2;
        tick();
        ld_issue = 1'b0;
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wait_nodone got %b want 0", done); end
        reg_wen = 1'b1; write_addr = 4'h9; write_data = 8'h5A;
        ld_issue = 1'b1; ld_addr = 4'hB;
        tick();
        clear_inputs();
        checks++; if (rf[79:72] !== m_live[9]) begin errors++; $display("FAIL wait_ignore_wr got %h want %h", rf[79:72], m_live[9]); end
        ld_ret = 1'b1; ld_ret_addr = 4'h2; ld_ret_data = 8'h99;
        tick();
        clear_inputs();
        checks++; if (rf[23:16] !== 8'h99) begin errors++; $display("FAIL wait_ret got %h want 99", rf[23:16]); end
        dn = 1'b0;
        for (int k = 0; k < 40 && !dn; k++) begin
            if (done) dn = 1'b1; else tick();
        end
        checks++; if (!dn) begin errors++; $display("FAIL wait_done timeout"); end
        write_reg(4'h2, 8'h00);
        write_reg(4'hB, 8'hEE);
        run_seq(1'b0, nb, dn);
        checks++; if (rf[23:16] !== 8'h99 || rf[95:88] !== m_live[11])
            begin errors++; $display("FAIL wait_saved got %h,%h want 99,%h", rf[23:16], rf[95:88], m_live[11]); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) write_reg(4'(i), 8'(8'h30 + i));
        ld_issue = 1'b1; ld_addr = 4'h0;
        tick();
        ld_issue = 1'b0; save_req = 1'b1;
        tick();
        save_req = 1'b0;
        checks++; if ({stall, busy} !== 2'b11) begin errors++; $display("FAIL pre_reset got %b want 11", {stall, busy}); end
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (rf !== 128'h0) begin errors++; $display("FAIL async_rf got %h want 0", rf); end
        checks++; if ({stall, busy} !== 2'b00) begin errors++; $display("FAIL async_flags got %b want 00", {stall, busy}); end
        #2 rst_n = 1'b1;
        write_reg(4'h6, 8'h66);
        begin
            int nb; bit dn;
            run_seq(1'b0, nb, dn);
        end
        checks++; if (rf !== 128'h0) begin errors++; $display("FAIL shadow_cleared got %h want 0", rf); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            acc_wen     = ($urandom_range(0, 7) == 0);
            reg_wen     = ($urandom_range(0, 3) == 0);
            write_addr  = 4'($urandom);
            write_data  = 8'($urandom);
            ld_issue    = ($urandom_range(0, 7) == 0);
            ld_addr     = 4'($urandom);
            ld_ret      = ($urandom_range(0, 2) == 0);
            ld_ret_addr = 4'($urandom);
            ld_ret_data = 8'($urandom);
            save_req    = ($urandom_range(0, 39) == 0);
            restore_req = ($urandom_range(0, 39) == 0);
            reg_read    = 1'($urandom);
            rt_addr     = 4'($urandom);
            #1;
            checks++; if (rs_val !== m_live[0]) begin errors++; $display("FAIL rnd_rs c=%0d got %h want %h", c, rs_val, m_live[0]); end
            checks++; if (rt_val !== exp_rt()) begin errors++; $display("FAIL rnd_rt c=%0d got %h want %h", c, rt_val, exp_rt()); end
            checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall c=%0d got %b want %b", c, stall, exp_stall()); end
            checks++; if (busy !== (m_phase != 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, m_phase != 0); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done c=%0d got %b want %b", c, done, m_done); end
            checks++; if (rf !== exp_rf()) begin errors++; $display("FAIL rnd_rf c=%0d got %h want %h", c, rf, exp_rf()); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_write_priority();
        test_scoreboard();
        test_collision();
        test_save_restore();
        test_wait_path();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_reg_file_v2.md
Name: acc_reg_file_v2

Overview:
- Parametrised next-generation accumulator register file for the CSE141L core.
- Entry 0 is the accumulator. It keeps the rs = accumulator / rt = register-or-immediate read model.
- Adds:
  - Configurable data width and depth.
  - A second write port for late load-return data, with a busy-bit scoreboard and stall output.
  - A shadow bank with a sequenced save/restore state machine for interrupt context switching.

Parameters:
- DW, 8: data width in bits.
- RAW, 4: register address width; DEPTH = 2**RAW entries.
- IMM_W, 4: immediate width on rt_addr_i path; must be <= RAW. Zero-extended to DW.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- rt_addr_i, input, RAW: rt read pointer / immediate source.
- reg_read_i, input, 1: 1 = rt from RF[rt_addr_i]; 0 = rt is zero-extended rt_addr_i[IMM_W-1:0].
- write_addr_i, input, RAW: ALU write pointer.
- acc_wen_i, input, 1: write write_data_i into RF[0].
- reg_wen_i, input, 1: write write_data_i into RF[write_addr_i].
- write_data_i, input, DW: ALU write data.
- ld_issue_i, input, 1: load issued; marks ld_addr_i busy.
- ld_addr_i, input, RAW: load destination.
- ld_ret_i, input, 1: load data returning.
- ld_ret_addr_i, input, RAW: returning load destination.
- ld_ret_data_i, input, DW: returning load data.
- save_req_i, input, 1: pulse; copy live bank to shadow.
- restore_req_i, input, 1: pulse; copy shadow to live bank.
- rs_val_o, output, DW: always RF[0].
- rt_val_o, output, DW: rt operand.
- stall_o, output, 1: a read (RF[0], or RF[rt_addr_i] when reg_read_i) targets a busy entry.
- busy_o, output, 1: save/restore sequence in progress or pending.
- done_o, output, 1: one-cycle pulse when a sequence completes.
- rf_o, output, DW*DEPTH: flattened live bank for debug; entry i at bits [i*DW +: DW].

Behaviour:
- Reset (async, rst_n low):
  - All live and shadow entries and all busy bits clear to 0.
  - FSM returns to IDLE.
  - busy_o=0, done_o=0, stall_o=0, rs_val_o=0, rt_val_o=0 (rt_val_o=0 while reg_read_i=1 or rt_addr_i=0).
  - Reset mid-sequence aborts it; partial copies are discarded by the clear.
- Reads: combinational, zero latency. rt immediate mode ignores busy bits.
- ALU write:
  - acc_wen_i has priority over reg_wen_i.
  - With both high, only RF[0] is written.
  - Writes land on the next rising edge.
- Load return:
  - Writes RF[ld_ret_addr_i] and clears its busy bit on the same edge.
  - Same-address collision with an ALU write in the same cycle: load return wins.
  - Different addresses: both writes occur.
- Scoreboard:
  - ld_issue_i sets busy[ld_addr_i].
  - ld_issue_i and ld_ret_i on the same address in the same cycle: busy stays set (the new load is outstanding).
  - An ALU write to a busy entry does not clear busy.
- stall_o = busy[0] | (reg_read_i & busy[rt_addr_i]). Purely combinational.
- FSM states: IDLE, WAIT, SAVE, RESTORE.
  - IDLE, request seen:
    - If any busy bit is set, go to WAIT and latch the direction.
    - Otherwise go to SAVE or RESTORE.
    - save_req_i wins if both requests arrive together.
  - WAIT: hold until all busy bits are clear, then go to the latched direction.
  - SAVE/RESTORE:
    - Index counter runs 0..DEPTH-1, one entry per cycle.
    - At DEPTH-1, return to IDLE and pulse done_o on that final copy edge, so done_o is high in the cycle after that edge.
    - Total DEPTH cycles from entry.
  - busy_o is high in WAIT, SAVE and RESTORE.
  - While busy_o is high: acc_wen_i, reg_wen_i and ld_issue_i are ignored. ld_ret_i is still accepted in WAIT.
  - Requests arriving while busy_o is high are dropped.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding.
  - Reads see same-cycle write data, using the write that would win at the edge.
  - stall_o is suppressed for an entry whose load return is arriving this cycle.
- Undefined: reads return the pre-edge contents; stall_o as specified above.

Decomposition:
- Shared package definitions (existing): rf_state_e enum (IDLE, WAIT, SAVE, RESTORE); default DW/RAW constants.
- Sub-module rf_ctx_seq: the FSM plus index counter; outputs copy index and direction.
- The array and scoreboard stay in the top module.

Test Plan:
- Reset: pulse rst_n low mid-clock with rf_o nonzero -> rf_o, busy_o and stall_o are 0 immediately, without waiting for clk.
- Write priority: acc_wen_i=reg_wen_i=1, write_addr_i=5, data 0x3C -> RF[0]=0x3C, RF[5] unchanged. Then reg_read_i=0, rt_addr_i=0xA -> rt_val_o=0x0A.
- Scoreboard: ld_issue_i addr 3, then reg_read_i=1, rt_addr_i=3 -> stall_o=1. ld_ret_i addr 3, data 0x77 -> next cycle stall_o=0, rt_val_o=0x77.
- Collision: reg_wen_i addr 7 data 0x11 plus ld_ret_i addr 7 data 0x22 in the same cycle -> RF[7]=0x22.
- Save/restore:
  - Fill RF[i]=i+1, save_req_i -> busy_o high for 16 cycles, done_o pulses.
  - Overwrite all entries with 0xFF, restore_req_i -> RF[i]=i+1.
- WAIT path: busy[2] set, save_req_i -> FSM in WAIT. reg_wen_i is ignored. ld_ret_i to 2 -> SAVE begins the next cycle.
